// File: rtl/block_path_guide.sv
// Validates block requests against the local occupancy map and lights a one-hot path lamp.
// It then tracks the car through the synchronized SENS_PAR edges and commits the block on arrival.
module block_path_guide #(
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CKT,
  input  logic       RSTN,
  input  logic [2:0] SEL,
  input  logic       SEL_VLD,
  input  logic [2:0] LV_SEL,
  input  logic       LV_VLD,
  input  logic       SENS_PAR,
  output logic [7:0] PATH,
  output logic       BUSY,
  output logic [7:0] OCC,
  output logic [2:0] FREE_CNT,
  output logic       FULL,
  output logic       DONE,
  output logic       REJ,
  output logic       TOUT
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GUIDE   = 2'd1;
  localparam logic [1:0] TRANSIT = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   par_s;
  logic                   par_rise;
  logic                   par_fall;

  logic [1:0]    state, state_n;
  logic [2:0]    cur, cur_n;
  logic [TW-1:0] timer, timer_n;
  logic [7:0]    path_n;
  logic          busy_n, done_n, rej_n, tout_n, commit;
  logic [7:0]    occ_n;
  logic [2:0]    used_cnt;
  logic [2:0]    free_n;

  always_ff @(posedge CKT or negedge RSTN) begin
    if (!RSTN) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], SENS_PAR};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign par_s    = sync_q[SYNC_STAGES-1];
  assign par_rise = par_s & ~hist_q;
  assign par_fall = ~par_s & hist_q;

  always_comb begin
    state_n = state;
    cur_n   = cur;
    timer_n = timer;
    path_n  = PATH;
    busy_n  = BUSY;
    done_n  = 1'b0;
    rej_n   = 1'b0;
    tout_n  = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (SEL_VLD && SEL != 3'd7) begin
          if (OCC[SEL]) begin
            rej_n = 1'b1;
          end else begin
            cur_n   = SEL;
            path_n  = 8'd1 << SEL;
            busy_n  = 1'b1;
            timer_n = '0;
            state_n = GUIDE;
          end
        end
      end
      GUIDE: begin
        timer_n = timer + 1'b1;
        rej_n   = SEL_VLD && SEL != 3'd7;
        // A car edge arriving on the last timer cycle still wins over abandoning.
        if (par_rise) begin
          state_n = TRANSIT;
        end else if (timer == TLAST) begin
          tout_n  = 1'b1;
          path_n  = 8'h80;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      TRANSIT: begin
        rej_n = SEL_VLD && SEL != 3'd7;
        if (par_fall) begin
          commit  = 1'b1;
          done_n  = 1'b1;
          path_n  = 8'h80;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        path_n  = 8'h80;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // Leave is applied before commit so a same-cycle commit to that block wins.
  always_comb begin
    occ_n = OCC;
    if (LV_VLD) occ_n[LV_SEL] = 1'b0;
    if (commit) occ_n[cur] = 1'b1;
    occ_n[7] = 1'b0;
    used_cnt = 3'd0;
    for (int i = 0; i < 7; i++) used_cnt = used_cnt + {2'b00, occ_n[i]};
    free_n = 3'd7 - used_cnt;
  end

  always_ff @(posedge CKT or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      cur      <= 3'd0;
      timer    <= '0;
      PATH     <= 8'h80;
      BUSY     <= 1'b0;
      OCC      <= 8'h00;
      FREE_CNT <= 3'd7;
      FULL     <= 1'b0;
      DONE     <= 1'b0;
      REJ      <= 1'b0;
      TOUT     <= 1'b0;
    end else begin
      state    <= state_n;
      cur      <= cur_n;
      timer    <= timer_n;
      PATH     <= path_n;
      BUSY     <= busy_n;
      OCC      <= occ_n;
      FREE_CNT <= free_n;
      FULL     <= (free_n == 3'd0);
      DONE     <= done_n;
      REJ      <= rej_n;
      TOUT     <= tout_n;
    end
  end

endmodule

// File: tb/tb_block_path_guide.sv
// Directed bench for block_path_guide: parking, rejection, timeout, fill/leave and reset cases.
module tb_block_path_guide;

  logic       CKT = 1'b0;
  logic       RSTN;
  logic [2:0] SEL;
  logic       SEL_VLD;
  logic [2:0] LV_SEL;
  logic       LV_VLD;
  logic       SENS_PAR;
  logic [7:0] PATH;
  logic       BUSY;
  logic [7:0] OCC;
  logic [2:0] FREE_CNT;
  logic       FULL;
  logic       DONE;
  logic       REJ;
  logic       TOUT;

  int tests = 0;
  int fails = 0;

  block_path_guide #(.TIMEOUT(8), .SYNC_STAGES(2)) dut (
    .CKT(CKT), .RSTN(RSTN), .SEL(SEL), .SEL_VLD(SEL_VLD), .LV_SEL(LV_SEL),
    .LV_VLD(LV_VLD), .SENS_PAR(SENS_PAR), .PATH(PATH), .BUSY(BUSY), .OCC(OCC),
    .FREE_CNT(FREE_CNT), .FULL(FULL), .DONE(DONE), .REJ(REJ), .TOUT(TOUT)
  );

  always #5 CKT = ~CKT;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge CKT);
  endtask

  task automatic park(input logic [2:0] blk);
    int k;
    logic [7:0] exp_path;
    exp_path = 8'd1 << blk;
    SEL = blk; SEL_VLD = 1'b1;
    cyc(1);
    SEL_VLD = 1'b0; SEL = 3'd7;
    tests++;
    if (PATH !== exp_path || BUSY !== 1'b1) begin
      fails++;
      $display("FAIL park_path blk=%0d: PATH=%h BUSY=%b, want PATH=%h BUSY=1", blk, PATH, BUSY, exp_path);
    end
    SENS_PAR = 1'b1;
    cyc(10);
    tests++;
    if (PATH !== exp_path || BUSY !== 1'b1 || TOUT !== 1'b0) begin
      fails++;
      $display("FAIL park_hold blk=%0d: PATH=%h BUSY=%b, want PATH=%h BUSY=1", blk, PATH, BUSY, exp_path);
    end
    SENS_PAR = 1'b0;
    k = 0;
    while (k < 12) begin
      cyc(1);
      k++;
      if (DONE === 1'b1) break;
    end
    tests++;
    if (DONE !== 1'b1 || k < 2 || k > 5) begin
      fails++;
      $display("FAIL park_done blk=%0d: DONE=%b after %0d cycles, want DONE=1 within 2..5", blk, DONE, k);
    end
    tests++;
    if (OCC[blk] !== 1'b1 || PATH !== 8'h80 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL park_commit blk=%0d: OCC=%h PATH=%h BUSY=%b, want bit set, PATH=80 BUSY=0", blk, OCC, PATH, BUSY);
    end
    cyc(1);
    tests++;
    if (DONE !== 1'b0) begin
      fails++;
      $display("FAIL park_done_pulse blk=%0d: DONE=%b, want 0", blk, DONE);
    end
  endtask

  task automatic leave(input logic [2:0] blk);
    LV_SEL = blk; LV_VLD = 1'b1;
    cyc(1);
    LV_VLD = 1'b0;
  endtask

  task automatic test_reset;
    RSTN = 1'b0;
    cyc(2);
    tests++;
    if (PATH !== 8'h80 || OCC !== 8'h00 || FREE_CNT !== 3'd7 || FULL !== 1'b0 ||
        BUSY !== 1'b0 || DONE !== 1'b0 || REJ !== 1'b0 || TOUT !== 1'b0) begin
      fails++;
      $display("FAIL reset: PATH=%h OCC=%h FREE=%0d FULL=%b BUSY=%b D/R/T=%b%b%b, want 80 00 7 0 0 000",
               PATH, OCC, FREE_CNT, FULL, BUSY, DONE, REJ, TOUT);
    end
    RSTN = 1'b1;
    cyc(1);
  endtask

  task automatic test_park5;
    park(3'd5);
    tests++;
    if (OCC !== 8'h20 || FREE_CNT !== 3'd6 || FULL !== 1'b0) begin
      fails++;
      $display("FAIL park5_map: OCC=%h FREE=%0d FULL=%b, want 20 6 0", OCC, FREE_CNT, FULL);
    end
  endtask

  task automatic test_reject;
    SEL = 3'd5; SEL_VLD = 1'b1;
    cyc(1);
    SEL_VLD = 1'b0;
    tests++;
    if (REJ !== 1'b1 || PATH !== 8'h80 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL reject_occupied: REJ=%b PATH=%h BUSY=%b, want 1 80 0", REJ, PATH, BUSY);
    end
    cyc(1);
    tests++;
    if (REJ !== 1'b0) begin
      fails++;
      $display("FAIL reject_pulse: REJ=%b, want 0", REJ);
    end
    SEL = 3'd7; SEL_VLD = 1'b1;
    cyc(1);
    SEL_VLD = 1'b0;
    tests++;
    if (REJ !== 1'b0 || PATH !== 8'h80 || BUSY !== 1'b0 || OCC !== 8'h20) begin
      fails++;
      $display("FAIL sel7_ignored: REJ=%b PATH=%h BUSY=%b OCC=%h, want 0 80 0 20", REJ, PATH, BUSY, OCC);
    end
  endtask

  task automatic test_timeout;
    int k;
    SEL = 3'd1; SEL_VLD = 1'b1;
    cyc(1);
    SEL_VLD = 1'b0;
    k = 0;
    while (TOUT !== 1'b1 && k < 20) begin
      cyc(1);
      k++;
    end
    tests++;
    if (TOUT !== 1'b1 || k != 8) begin
      fails++;
      $display("FAIL timeout_latency: TOUT=%b at %0d cycles after entry, want 1 at 8", TOUT, k);
    end
    tests++;
    if (PATH !== 8'h80 || BUSY !== 1'b0 || OCC !== 8'h20) begin
      fails++;
      $display("FAIL timeout_state: PATH=%h BUSY=%b OCC=%h, want 80 0 20", PATH, BUSY, OCC);
    end
    cyc(1);
    tests++;
    if (TOUT !== 1'b0) begin
      fails++;
      $display("FAIL timeout_pulse: TOUT=%b, want 0", TOUT);
    end
  endtask

  task automatic test_fill_leave;
    logic [2:0] order [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    foreach (order[i]) park(order[i]);
    tests++;
    if (OCC !== 8'h7F || FULL !== 1'b1 || FREE_CNT !== 3'd0) begin
      fails++;
      $display("FAIL full: OCC=%h FULL=%b FREE=%0d, want 7f 1 0", OCC, FULL, FREE_CNT);
    end
    leave(3'd2);
    tests++;
    if (OCC !== 8'h7B || FULL !== 1'b0 || FREE_CNT !== 3'd1) begin
      fails++;
      $display("FAIL leave2: OCC=%h FULL=%b FREE=%0d, want 7b 0 1", OCC, FULL, FREE_CNT);
    end
    leave(3'd7);
    tests++;
    if (OCC !== 8'h7B || FREE_CNT !== 3'd1) begin
      fails++;
      $display("FAIL leave7_noop: OCC=%h FREE=%0d, want 7b 1", OCC, FREE_CNT);
    end
  endtask

  task automatic test_transit_collision;
    int k;
    leave(3'd4);
    tests++;
    if (OCC !== 8'h6B || FREE_CNT !== 3'd2) begin
      fails++;
      $display("FAIL leave4: OCC=%h FREE=%0d, want 6b 2", OCC, FREE_CNT);
    end
    SEL = 3'd4; SEL_VLD = 1'b1;
    cyc(1);
    SEL_VLD = 1'b0;
    SENS_PAR = 1'b1;
    cyc(5);
    SEL = 3'd0; SEL_VLD = 1'b1;
    cyc(1);
    SEL_VLD = 1'b0;
    tests++;
    if (REJ !== 1'b1 || BUSY !== 1'b1 || PATH !== 8'h10) begin
      fails++;
      $display("FAIL transit_reject: REJ=%b BUSY=%b PATH=%h, want 1 1 10", REJ, BUSY, PATH);
    end
    // Keep the leave strobe up until the commit lands so the two coincide.
    SENS_PAR = 1'b0;
    LV_SEL = 3'd4; LV_VLD = 1'b1;
    k = 0;
    while (k < 12) begin
      cyc(1);
      k++;
      if (DONE === 1'b1) break;
    end
    LV_VLD = 1'b0;
    tests++;
    if (DONE !== 1'b1 || OCC !== 8'h7B || FREE_CNT !== 3'd1) begin
      fails++;
      $display("FAIL commit_vs_leave: DONE=%b OCC=%h FREE=%0d, want 1 7b 1", DONE, OCC, FREE_CNT);
    end
    cyc(1);
  endtask

  task automatic test_reset_in_transit;
    leave(3'd3);
    SEL = 3'd3; SEL_VLD = 1'b1;
    cyc(1);
    SEL_VLD = 1'b0;
    SENS_PAR = 1'b1;
    cyc(5);
    tests++;
    if (BUSY !== 1'b1 || PATH !== 8'h08) begin
      fails++;
      $display("FAIL transit3_setup: BUSY=%b PATH=%h, want 1 08", BUSY, PATH);
    end
    RSTN = 1'b0;
    SENS_PAR = 1'b0;
    #1;
    tests++;
    if (PATH !== 8'h80 || OCC !== 8'h00 || BUSY !== 1'b0 || FREE_CNT !== 3'd7 ||
        FULL !== 1'b0 || DONE !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: PATH=%h OCC=%h BUSY=%b FREE=%0d FULL=%b DONE=%b, want 80 00 0 7 0 0",
               PATH, OCC, BUSY, FREE_CNT, FULL, DONE);
    end
    cyc(2);
    RSTN = 1'b1;
    cyc(5);
    tests++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || OCC !== 8'h00) begin
      fails++;
      $display("FAIL post_reset_idle: DONE=%b BUSY=%b OCC=%h, want 0 0 00", DONE, BUSY, OCC);
    end
  endtask

  initial begin
    RSTN = 1'b0; SEL = 3'd7; SEL_VLD = 1'b0; LV_SEL = 3'd7; LV_VLD = 1'b0; SENS_PAR = 1'b0;
    test_reset;
    test_park5;
    test_reject;
    test_timeout;
    test_fill_leave;
    test_transit_collision;
    test_reset_in_transit;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
